// File: rtl/key_schedule_unit_pkg.sv
// AESDefinitions: AES-128 types, round constants, key-schedule state encoding and
// the S-box, shared by the key schedule and the Round/RoundInverse datapath.
package AESDefinitions;

    typedef logic [127:0] roundKey_t;

    // Index of the last round key (AES-128: keys 0..10).
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Round constants indexed by round number; entry 0 is never used by the expansion.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FILL   = 2'd2,
        REPLAY = 2'd3
    } keySchedState_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Out-of-range rounds return zero so the look-ahead at the last key stays defined.
    function automatic logic [7:0] rconFor(input logic [3:0] r);
        return (r <= NUM_ROUNDS) ? RCON[r] : 8'h00;
    endfunction

endpackage

// File: rtl/key_schedule_unit_sub_word.sv
// key_sub_word: RotWord + SubWord on w3 with the round constant folded into the top byte,
// giving the word t that seeds the next round key.
module key_sub_word
    import AESDefinitions::*;
(
    input  logic [31:0] w3,
    input  logic [7:0]  rcon,
    output logic [31:0] t
);

    logic [31:0] rotWord;

    assign rotWord = {w3[23:0], w3[31:24]};

    assign t = {sbox(rotWord[31:24]) ^ rcon,
                sbox(rotWord[23:16]),
                sbox(rotWord[15:8]),
                sbox(rotWord[7:0])};

endmodule

// File: rtl/key_schedule_unit.sv
// key_schedule_unit: iterative AES-128 key expansion, one round key per cycle, streamed
// with its index over a valid/ready port. Define KEY_REPLAY_EN to add the inverse input
// and an 11-entry buffer that replays the keys from the last round down to key 0.
//
//   state  | meaning
//   IDLE   | keyReady high, waiting for a cipher key
//   STREAM | presenting keys 0..NUM_ROUNDS in order, advancing on each transfer
//   FILL   | expanding all keys into the replay buffer, nothing presented
//   REPLAY | presenting buffered keys NUM_ROUNDS..0, advancing on each transfer
module key_schedule_unit
    import AESDefinitions::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        keyValid,
    input  logic [127:0] keyIn,
`ifdef KEY_REPLAY_EN
    input  logic        inverse,
`endif
    output logic        keyReady,
    output logic        rkValid,
    input  logic        rkReady,
    output logic [3:0]  rkIndex,
    output roundKey_t   rkOut,
    output logic        done
);

    keySchedState_t state;
    roundKey_t      workKey;
    roundKey_t      nextKey;
    logic [3:0]     roundIdx;
    logic [3:0]     nextIdx;
    logic [7:0]     roundRcon;
    logic [31:0]    t;
    logic [31:0]    w0n, w1n, w2n, w3n;
    logic           startFill;

    assign nextIdx   = roundIdx + 4'd1;
    assign roundRcon = rconFor(nextIdx);

    key_sub_word uSubWord (
        .w3   (workKey[31:0]),
        .rcon (roundRcon),
        .t    (t)
    );

    assign w0n     = workKey[127:96] ^ t;
    assign w1n     = workKey[95:64]  ^ w0n;
    assign w2n     = workKey[63:32]  ^ w1n;
    assign w3n     = workKey[31:0]   ^ w2n;
    assign nextKey = {w0n, w1n, w2n, w3n};

`ifdef KEY_REPLAY_EN
    roundKey_t  keyBuf [0:NUM_ROUNDS];
    logic [3:0] prevIdx;

    assign startFill = inverse;
    assign prevIdx   = roundIdx - 4'd1;

    // Replay storage is written during FILL only; it needs no reset since stale contents are never read.
    always_ff @(posedge clock) begin
        if (state == FILL) begin
            keyBuf[roundIdx] <= workKey;
        end
    end
`else
    assign startFill = 1'b0;
`endif

    // done must coincide with the transfer itself, so it gates the registered final-key
    // condition with rkReady; rkOut/rkIndex/rkValid never see rkReady combinationally.
    assign done = rkValid && rkReady &&
                  ((state == STREAM) ? (rkIndex == NUM_ROUNDS) : (rkIndex == 4'd0));

    // Sequencing FSM: working key, round counter and all registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            workKey  <= '0;
            roundIdx <= '0;
            keyReady <= 1'b1;
            rkValid  <= 1'b0;
            rkIndex  <= '0;
            rkOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (keyValid) begin
                        workKey  <= keyIn;
                        roundIdx <= '0;
                        rkIndex  <= '0;
                        keyReady <= 1'b0;
                        if (startFill) begin
                            state <= FILL;
                        end else begin
                            state   <= STREAM;
                            rkValid <= 1'b1;
                            rkOut   <= keyIn;
                        end
                    end
                end
                STREAM: begin
                    if (rkReady) begin
                        if (roundIdx == NUM_ROUNDS) begin
                            state    <= IDLE;
                            rkValid  <= 1'b0;
                            keyReady <= 1'b1;
                        end else begin
                            workKey  <= nextKey;
                            rkOut    <= nextKey;
                            roundIdx <= nextIdx;
                            rkIndex  <= nextIdx;
                        end
                    end
                end
`ifdef KEY_REPLAY_EN
                FILL: begin
                    if (roundIdx == NUM_ROUNDS) begin
                        // The last key is still in workKey, so present it without a buffer read.
                        state   <= REPLAY;
                        rkValid <= 1'b1;
                        rkOut   <= workKey;
                        rkIndex <= NUM_ROUNDS;
                    end else begin
                        workKey  <= nextKey;
                        roundIdx <= nextIdx;
                    end
                end
                REPLAY: begin
                    if (rkReady) begin
                        if (roundIdx == 4'd0) begin
                            state    <= IDLE;
                            rkValid  <= 1'b0;
                            keyReady <= 1'b1;
                        end else begin
                            rkOut    <= keyBuf[prevIdx];
                            roundIdx <= prevIdx;
                            rkIndex  <= prevIdx;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_schedule_unit.md
# key_schedule_unit

Iterative AES-128 key expansion stage directly upstream of `Round`/`RoundInverse`. Accepts a 128-bit cipher key over a valid/ready handshake and computes one round key per cycle. Streams round keys 0..`NUM_ROUNDS` with an index, so the round pipeline can latch `roundKey_t` per stage. An optional replay buffer emits the keys in reverse order for the decryption path.

## Interface
- `NUM_ROUNDS` (package constant/macro), default 10: last round-key index.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `keyValid`  in  1  cipher key offered.
- `keyIn`  in  128  cipher key. `[127:96]` is word w0.
- `keyReady`  out  1  high only in IDLE.
- `inverse`  in  1  sampled at accept; present only with `KEY_REPLAY_EN`.
- `rkValid`  out  1  `rkOut`/`rkIndex` are valid.
- `rkReady`  in  1  downstream accepts the key; a transfer occurs when `rkValid && rkReady`.
- `rkIndex`  out  4  round number of `rkOut`.
- `rkOut`  out  128  `roundKey_t` round key.
- `done`  out  1  one-cycle pulse on the transfer of the final key.

## Operation
- **States:** IDLE, STREAM, and with the macro also FILL and REPLAY.
- **IDLE:**
  - `keyReady`=1.
  - On `keyValid`, capture `keyIn` into the working register and set index=0.
  - Go to STREAM, or to FILL if `inverse`=1.
- **STREAM:**
  - `rkValid`=1 and `rkOut`=working register.
  - On each transfer, the working register becomes expand(working, rcon[index+1]) and the index increments.
  - The transfer at index `NUM_ROUNDS` asserts `done` and returns to IDLE.
  - With `rkReady`=0, all outputs hold stable.
- **Expansion:**
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Constant ROM indexed by round, not computed by xtime.
- **FILL:**
  - `rkValid`=0.
  - Write key 0..`NUM_ROUNDS` into an 11×128 buffer, one per cycle, with no stall.
- **REPLAY:**
  - Stream buffer entries `NUM_ROUNDS` down to 0, honouring `rkReady`.
  - The transfer at index 0 asserts `done` and returns to IDLE.
- **Ignored input:** `keyValid` outside IDLE is ignored. The key is not queued.
- **Reset mid-operation:** forces IDLE immediately and drops `rkValid` asynchronously. Buffer contents become don't-care.

## Timing
- **Reset values:** `keyReady`=1, `rkValid`=0, `rkIndex`=0, `rkOut`=0, `done`=0.
- **Forward latency:**
  - Accept at edge N gives key 0 valid after edge N.
  - With `rkReady` held high, key i is valid in cycle N+1+i and key 10 in cycle N+11.
  - `done` is high during cycle N+11.
  - `keyReady` rises after edge N+11, so back-to-back keys are spaced 12 cycles apart.
- **Reverse latency:** FILL occupies 11 cycles after accept. Key 10 is valid after edge N+11 and key 0 in cycle N+22 with no stall.
- **Outputs:** all registered; no combinational path from `rkReady` to `rkOut`.
- **SubWord:** purely combinational within one cycle.

## Configuration
- **`KEY_REPLAY_EN` defined:**
  - The `inverse` port, the FILL/REPLAY states and the 11-entry buffer exist.
  - `inverse`=0 behaves exactly as without the macro.
- **Not defined:** no `inverse` port and no buffer; forward streaming only.

## Structure
- **Shared package `AESDefinitions`:**
  - `roundKey_t`, `NUM_ROUNDS`.
  - The rcon table as a localparam array.
  - The state enum `keySchedState_t`.
  - The S-box function, shared with `Round`.
- **Sub-module `key_sub_word`:** combinational RotWord + SubWord + rcon XOR on w3, producing t.
- The top-level contains the FSM, working register, index counter and replay buffer.

## Test plan
- **FIPS-197 A.1 forward:** key 2b7e151628aed2a6abf7158809cf4f3c with `rkReady`=1.
  - Key 0 = input.
  - Key 1 = a0fafe1788542cb123a339392a6c7605.
  - Key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done` in cycle N+11.
- **FIPS-197 C.1 forward:** key 000102030405060708090a0b0c0d0e0f.
  - Key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Result matches the key2 constant used by the last-round test.
- **Backpressure:** drop `rkReady` for 3 cycles at index 4.
  - `rkOut`/`rkIndex` hold key 4.
  - The sequence then resumes intact.
  - Key 10 is still correct and `done` appears at cycle N+14.
- **Busy and back-to-back:** assert `keyValid` with a different key during STREAM.
  - The key is ignored, `keyReady`=0 and the output sequence is unchanged.
  - A new key offered when `keyReady` returns is accepted 12 cycles after the first.
- **Reset mid-stream:** assert `reset` at index 6.
  - `rkValid` falls without a clock edge and `keyReady`=1.
  - A following C.1 key produces a correct full sequence.
- **Reverse order (`KEY_REPLAY_EN`):** C.1 key with `inverse`=1.
  - First valid output is index 10 = 13111d7fe3944a17f307a78b4d2b30c5 in cycle N+12.
  - Last output is index 0 = 000102030405060708090a0b0c0d0e0f, with `done`.
